// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the oversampling UART receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rxState_e;

    // Flag positions above the payload inside one FIFO entry.
    localparam int FLAG_PERR = 0;
    localparam int FLAG_FERR = 1;
    localparam int FLAG_BRK  = 2;
    localparam int NUM_FLAGS = 3;

    function automatic int calcDiv(input int clkHz, input int bitRate, input int ovs);
        return clkHz / (bitRate * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr_q == rdPtr_q);
    assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign doPush = push && (!full || doPop);
    assign dout   = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote,
// configurable framing, error/break flags and a FWFT frame FIFO.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_parity_err,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    input  logic                    uart_rx_ready,
    output logic                    uart_rx_overflow,
    output logic                    uart_rx_busy
);

    localparam int DIV     = calcDiv(CLK_HZ, BIT_RATE, OVERSAMPLE);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W     = $clog2(OVERSAMPLE);
    localparam int B_W     = $clog2(PAYLOAD_BITS);
    localparam int ENTRY_W = PAYLOAD_BITS + NUM_FLAGS;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_V0      = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_V1      = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0]   S_V2      = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0]   S_LAST    = S_W'(OVERSAMPLE - 1);
    localparam logic [B_W-1:0]   DATA_LAST = B_W'(PAYLOAD_BITS - 1);
    localparam logic [B_W-1:0]   STOP_LAST = B_W'(STOP_BITS - 1);

    if (DIV < 1) begin : g_divCheck
        $error("uart_rx_ovs: CLK_HZ too low for BIT_RATE * OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
        PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_paramCheck
        $error("uart_rx_ovs: parameter out of range");
    end

    logic                    rxMeta_q, rxSync_q;
    logic [DIV_W-1:0]        divCnt_q, divCnt_d;
    rxState_e                state_q, state_d;
    logic [S_W-1:0]          s_q, s_d;
    logic [B_W-1:0]          bitIdx_q, bitIdx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [1:0]              vote_q, vote_d;
    logic                    parErr_q, parErr_d;
    logic                    frmErr_q, frmErr_d;
    logic                    overflow_q;

    logic                    tick, voted, atVote, atEnd;
    logic                    frmNow, brkNow, commit, popNow;
    logic [ENTRY_W-1:0]      entry, fifoDout;
    logic                    fifoFull, fifoEmpty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= uart_rxd;
            rxSync_q <= rxMeta_q;
        end
    end

    // The third vote sample is the live synchronised line at the last window tick.
    assign tick   = (divCnt_q == DIV_LAST);
    assign voted  = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxSync_q) | (vote_q[0] & rxSync_q);
    assign atVote = tick && (s_q == S_V2);
    assign atEnd  = tick && (s_q == S_LAST);
    assign frmNow = frmErr_q | ~voted;
    assign brkNow = frmNow && (shift_q == '0);

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        vote_d   = vote_q;
        parErr_d = parErr_q;
        frmErr_d = frmErr_q;
        divCnt_d = tick ? '0 : divCnt_q + 1'b1;
        commit   = 1'b0;

        if (state_q != ST_IDLE && state_q != ST_BREAK_WAIT && tick) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
            if (s_q == S_V0 || s_q == S_V1) vote_d = {vote_q[0], rxSync_q};
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxSync_q && uart_rx_en) begin
                    state_d  = ST_START;
                    s_d      = '0;
                    divCnt_d = '0;
                    bitIdx_d = '0;
                    parErr_d = 1'b0;
                    frmErr_d = 1'b0;
                end
            end
            ST_START: begin
                if (atVote && voted) state_d = ST_IDLE;
                else if (atEnd)      state_d = ST_DATA;
            end
            ST_DATA: begin
                if (atVote) shift_d = {voted, shift_q[PAYLOAD_BITS-1:1]};
                if (atEnd) begin
                    if (bitIdx_q == DATA_LAST) begin
                        bitIdx_d = '0;
                        state_d  = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (atVote) parErr_d = ((^shift_q) ^ voted) != (PARITY == PARITY_ODD);
                if (atEnd)  state_d  = ST_STOP;
            end
            ST_STOP: begin
                // Commit at the last stop vote so a following start edge is not missed.
                if (atVote) begin
                    frmErr_d = frmNow;
                    if (bitIdx_q == STOP_LAST) begin
                        commit  = 1'b1;
                        state_d = brkNow ? ST_BREAK_WAIT : ST_IDLE;
                    end
                end
                if (atEnd) bitIdx_d = bitIdx_q + 1'b1;
            end
            ST_BREAK_WAIT: begin
                if (rxSync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            divCnt_q   <= '0;
            s_q        <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            vote_q     <= '0;
            parErr_q   <= 1'b0;
            frmErr_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            s_q        <= s_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            vote_q     <= vote_d;
            parErr_q   <= parErr_d;
            frmErr_q   <= frmErr_d;
            overflow_q <= commit && fifoFull && !popNow;
        end
    end

    always_comb begin
        entry                            = '0;
        entry[PAYLOAD_BITS-1:0]          = shift_q;
        entry[PAYLOAD_BITS + FLAG_PERR]  = parErr_q;
        entry[PAYLOAD_BITS + FLAG_FERR]  = frmNow;
        entry[PAYLOAD_BITS + FLAG_BRK]   = brkNow;
    end

    assign popNow = uart_rx_valid && uart_rx_ready;

    uart_rx_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (commit),
        .din   (entry),
        .pop   (popNow),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign uart_rx_valid      = !fifoEmpty;
    assign uart_rx_data       = fifoDout[PAYLOAD_BITS-1:0];
    assign uart_rx_parity_err = fifoDout[PAYLOAD_BITS + FLAG_PERR];
    assign uart_rx_frame_err  = fifoDout[PAYLOAD_BITS + FLAG_FERR];
    assign uart_rx_break      = fifoDout[PAYLOAD_BITS + FLAG_BRK];
    assign uart_rx_overflow   = overflow_q;
    assign uart_rx_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Randomised scoreboard bench for uart_rx_ovs: an 8N1 instance and an 8E1 instance,
// each with its own line, expected-entry queue and monitor.
module tb_uart_rx_ovs;

    localparam int BIT_CYC      = 16;
    localparam int COMMIT_N     = 156;
    localparam int DEPTH        = 4;
    localparam int MODE_NORMAL  = 0;
    localparam int MODE_DROP    = 1;
    localparam int MODE_RDYPULS = 2;
    localparam int MODE_ENDROP  = 3;
    localparam int MODE_RESET   = 4;
    localparam int MODE_DISABLE = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd = 1'b1, rxdP = 1'b1;
    logic en = 1'b1;
    logic rdy = 1'b1, rdyP = 1'b1;

    logic [7:0] dataM, dataP;
    logic perrM, ferrM, brkM, validM, ovfM, busyM;
    logic perrP, ferrP, brkP, validP, ovfP, busyP;
    logic [10:0] headM, headP, prevHeadM, prevHeadP;
    logic stallM = 1'b0, stallP = 1'b0;

    logic [10:0] expQ[$];
    logic [10:0] expQP[$];
    int total = 0;
    int bad = 0;
    int ovfCountM = 0;
    int ovfCountP = 0;

    always #5 clk = ~clk;

    uart_rx_ovs #(
        .CLK_HZ(16_000_000), .BIT_RATE(1_000_000), .OVERSAMPLE(16), .PAYLOAD_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .uart_rxd(rxd), .uart_rx_en(en),
        .uart_rx_data(dataM), .uart_rx_parity_err(perrM), .uart_rx_frame_err(ferrM),
        .uart_rx_break(brkM), .uart_rx_valid(validM), .uart_rx_ready(rdy),
        .uart_rx_overflow(ovfM), .uart_rx_busy(busyM)
    );

    uart_rx_ovs #(
        .CLK_HZ(16_000_000), .BIT_RATE(1_000_000), .OVERSAMPLE(16), .PAYLOAD_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dutPar (
        .clk(clk), .reset(reset), .uart_rxd(rxdP), .uart_rx_en(1'b1),
        .uart_rx_data(dataP), .uart_rx_parity_err(perrP), .uart_rx_frame_err(ferrP),
        .uart_rx_break(brkP), .uart_rx_valid(validP), .uart_rx_ready(rdyP),
        .uart_rx_overflow(ovfP), .uart_rx_busy(busyP)
    );

    assign headM = {brkM, ferrM, perrM, dataM};
    assign headP = {brkP, ferrP, perrP, dataP};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [10:0] actual);
        total++;
        bad++;
        $display("[TB] FAIL %s: actual=%0h required=no entry", name, actual);
    endtask

    // Expected FIFO entry {break, frame_err, parity_err, data} from the bits put on the line.
    function automatic logic [10:0] modelEntry(input bit withPar, input logic [7:0] data,
                                               input bit pbit, input bit stopBit);
        bit perr, ferr, brk;
        perr = withPar && ((($countones(data) + int'(pbit)) % 2) != 0);
        ferr = !stopBit;
        brk  = ferr && (data == 8'h00);
        return {brk, ferr, perr, data};
    endfunction

    task automatic applyStimulus(input bit toPar, input logic [7:0] data, input bit badPar,
                                 input bit badStop, input int mode);
        bit frame[$];
        bit pbit;
        pbit = (($countones(data) % 2) == 1) ^ badPar;
        frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) frame.push_back(data[i]);
        if (toPar) frame.push_back(pbit);
        frame.push_back(!badStop);
        if (mode == MODE_NORMAL || mode == MODE_RDYPULS || mode == MODE_ENDROP) begin
            if (toPar) expQP.push_back(modelEntry(1'b1, data, pbit, !badStop));
            else       expQ.push_back(modelEntry(1'b0, data, pbit, !badStop));
        end
        if (mode == MODE_DISABLE) en = 1'b0;
        @(posedge clk);
        fork
            begin
                for (int i = 0; i < frame.size(); i++) begin
                    #1;
                    if (toPar) rxdP = frame[i];
                    else       rxd  = frame[i];
                    if (mode == MODE_RESET && i == 4) begin
                        repeat (8) @(posedge clk);
                        #1 reset = 1'b1;
                        rxd = 1'b1;
                        repeat (3) @(posedge clk);
                        #1 reset = 1'b0;
                        break;
                    end
                    repeat (BIT_CYC) @(posedge clk);
                end
                #1;
                rxd  = 1'b1;
                rxdP = 1'b1;
            end
            begin
                if (mode == MODE_RDYPULS) begin
                    repeat (COMMIT_N) @(posedge clk);
                    #1 rdy = 1'b1;
                    @(posedge clk);
                    #1 rdy = 1'b0;
                end
                if (mode == MODE_ENDROP) begin
                    repeat (3 * BIT_CYC) @(posedge clk);
                    #1 en = 1'b0;
                end
            end
        join
        en = 1'b1;
        repeat (20 + $urandom_range(0, 20)) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stallM = 1'b0;
        end else begin
            if (validM && stallM) checkOutput("mainHeadHold", headM, prevHeadM);
            if (validM && rdy) begin
                if (expQ.size() == 0) reportUnexpected("mainUnexpectedEntry", headM);
                else                  checkOutput("mainEntry", headM, expQ.pop_front());
            end
            if (ovfM) ovfCountM++;
            stallM    = validM && !rdy;
            prevHeadM = headM;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stallP = 1'b0;
        end else begin
            if (validP && stallP) checkOutput("parHeadHold", headP, prevHeadP);
            if (validP && rdyP) begin
                if (expQP.size() == 0) reportUnexpected("parUnexpectedEntry", headP);
                else                   checkOutput("parEntry", headP, expQP.pop_front());
            end
            if (ovfP) ovfCountP++;
            stallP    = validP && !rdyP;
            prevHeadP = headP;
        end
    end

    initial begin
        bit busySeen;
        bit toPar;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetData", dataM, 0);
        checkOutput("resetParityErr", perrM, 0);
        checkOutput("resetFrameErr", ferrM, 0);
        checkOutput("resetBreak", brkM, 0);
        checkOutput("resetValid", validM, 0);
        checkOutput("resetOverflow", ovfM, 0);
        checkOutput("resetBusy", busyM, 0);
        checkOutput("resetValidPar", validP, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] 8N1 basic frames");
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, MODE_NORMAL);
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, MODE_NORMAL);

        $display("[TB] even parity good and bad");
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, MODE_NORMAL);
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, MODE_NORMAL);

        $display("[TB] start glitch");
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        busySeen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busyM) busySeen = 1'b1;
        end
        checkOutput("glitchBusySeen", busySeen, 1);
        checkOutput("glitchBusyAfter", busyM, 0);
        checkOutput("glitchNoValid", validM, 0);
        @(posedge clk);
        #1;

        $display("[TB] break");
        expQ.push_back(modelEntry(1'b0, 8'h00, 1'b0, 1'b0));
        rxd = 1'b0;
        repeat (20 * BIT_CYC - 1) @(posedge clk);
        @(negedge clk);
        checkOutput("breakBusyWhileLow", busyM, 1);
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("breakBusyReleased", busyM, 0);
        repeat (20) @(posedge clk);
        #1;

        $display("[TB] overflow");
        rdy = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v == 5) checkOutput("ovfBeforeFifth", ovfCountM, 0);
            applyStimulus(1'b0, 8'(v), 1'b0, 1'b0, (expQ.size() >= DEPTH) ? MODE_DROP : MODE_NORMAL);
        end
        checkOutput("ovfAfterFifth", ovfCountM, 1);
        rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("drainedFour", expQ.size(), 0);
        rdy = 1'b0;
        for (int v = 0; v < 4; v++) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, MODE_NORMAL);
        applyStimulus(1'b0, 8'h06, 1'b0, 1'b0, MODE_RDYPULS);
        checkOutput("ovfReadyOnCommit", ovfCountM, 1);
        rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, MODE_RESET);
        @(negedge clk);
        checkOutput("abortNoValid", validM, 0);
        checkOutput("abortNotBusy", busyM, 0);
        checkOutput("abortNoOverflow", ovfCountM, 1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h12, 1'b0, 1'b0, MODE_NORMAL);

        $display("[TB] receive enable");
        applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, MODE_DISABLE);
        applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, MODE_ENDROP);

        $display("[TB] random frames");
        for (int n = 0; n < 30; n++) begin
            toPar = ($urandom_range(0, 1) == 1);
            if (toPar) rdyP = (expQP.size() >= 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
            else       rdy  = (expQ.size()  >= 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
            applyStimulus(toPar, 8'($urandom), toPar && ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0), MODE_NORMAL);
        end

        rdy  = 1'b1;
        rdyP = 1'b1;
        for (int i = 0; i < 400 && (expQ.size() != 0 || expQP.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        checkOutput("finalQueueMain", expQ.size(), 0);
        checkOutput("finalQueuePar", expQP.size(), 0);
        checkOutput("finalOverflowMain", ovfCountM, 1);
        checkOutput("finalOverflowPar", ovfCountP, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
